axis_capture_sink: RTL and testbench

// Synthesizable, parametrised AXI-Stream sink. It applies configurable backpressure from an LFSR,

---
 rtl/axis_capture_sink.sv | 133 +++++++++++++
 tb/tb_axis_capture_sink.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_capture_sink.sv
// AXI-Stream capture sink: LFSR/pattern driven backpressure, keep-based word
// compaction into a capture memory, per-packet length/count reporting and a
// registered 1-cycle read port for pulling captured words back out.
module axis_capture_sink #(
   parameter int          WORD_W     = 8,
   parameter int          BUS_W      = 32,
   parameter int          DEPTH      = 256,
   parameter int          PROB_READY = 20,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   localparam int         WPB        = BUS_W / WORD_W,
   localparam int         AW         = $clog2(DEPTH),
   localparam int         CW         = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m_valid,
   input  logic                   m_last,
   input  logic [WPB-1:0]         m_keep,
   input  logic [WPB*WORD_W-1:0]  m_data,
   output logic                   m_ready,
   input  logic [1:0]             ready_mode,
   input  logic                   clear,
   input  logic [AW-1:0]          rd_addr,
   output logic [WORD_W-1:0]      rd_data,
   output logic [CW-1:0]          wr_count,
   output logic [31:0]            pkt_count,
   output logic                   pkt_done,
   output logic [CW-1:0]          pkt_len,
   output logic                   full
);

   // 100% maps to 256 so the 9-bit compare below is always true
   localparam int THRESH = (PROB_READY * 256) / 100;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [15:0]       lfsr;
   logic              toggle;
   logic [CW-1:0]     cur_len;
   logic              gen_rdy;
   logic              accept;
   logic [CW-1:0]     beat_cnt;
   logic [CW-1:0]     wr_count_next;
   logic [CW-1:0]     room_next;
   logic [AW-1:0]     word_addr [WPB];

   // Raw ready pattern before the room/clear qualification
   always_comb begin
      gen_rdy = 1'b0;
      case (ready_mode)
         2'd0:    gen_rdy = 1'b1;
         2'd1:    gen_rdy = ({1'b0, lfsr[7:0]} < 9'(THRESH));
         2'd2:    gen_rdy = 1'b0;
         default: gen_rdy = toggle;
      endcase
   end

   // Compaction: each kept word lands at wr_count plus the number of kept
   // words below it; beat_cnt ends up as the beat's popcount
   always_comb begin
      beat_cnt = '0;
      for (int i = 0; i < WPB; i++) begin
         word_addr[i] = AW'(wr_count + beat_cnt);
         beat_cnt     = beat_cnt + CW'(m_keep[i]);
      end
   end

   assign accept        = m_valid && m_ready;
   assign wr_count_next = clear ? '0 : (accept ? wr_count + beat_cnt : wr_count);
   assign room_next     = CW'(DEPTH) - wr_count_next;
   assign full          = (CW'(DEPTH) - wr_count) < CW'(WPB);

   // Free-running Fibonacci LFSR (taps 16,14,13,11) and alternate toggle;
   // clear deliberately leaves both running
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr   <= LFSR_SEED;
         toggle <= 1'b0;
      end else begin
         lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         toggle <= ~toggle;
      end
   end

   // Registered ready: only offered when a whole beat still fits after this cycle
   always_ff @(posedge clk) begin
      if (rst) m_ready <= 1'b0;
      else     m_ready <= gen_rdy && !clear && (room_next >= CW'(WPB));
   end

   // Capture and packet bookkeeping; a beat handshaken during clear is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_count  <= '0;
         cur_len   <= '0;
         pkt_count <= '0;
         pkt_done  <= 1'b0;
         pkt_len   <= '0;
      end else begin
         pkt_done <= 1'b0;
         wr_count <= wr_count_next;
         if (clear) begin
            cur_len   <= '0;
            pkt_count <= '0;
            pkt_len   <= '0;
         end else if (accept) begin
            if (m_last) begin
               pkt_done  <= 1'b1;
               pkt_len   <= cur_len + beat_cnt;
               pkt_count <= pkt_count + 32'd1;
               cur_len   <= '0;
            end else begin
               cur_len   <= cur_len + beat_cnt;
            end
         end
      end
   end

   // Capture memory write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (!rst && accept && !clear) begin
         for (int i = 0; i < WPB; i++) begin
            if (m_keep[i]) mem[word_addr[i]] <= m_data[i*WORD_W +: WORD_W];
         end
      end
   end

   // Registered read port; same-cycle write to rd_addr returns the old word
   always_ff @(posedge clk) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end

endmodule

// File: tb/tb_axis_capture_sink.sv
// Bench for axis_capture_sink (8-bit words, 32-bit bus, 16-word memory):
// directed scenarios with literal expectations plus a randomized phase,
// all outputs compared every cycle against a behavioural model.
module tb_axis_capture_sink;

   localparam int DEPTH  = 16;
   localparam int WPB    = 4;
   localparam int THRESH = (20 * 256) / 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_valid = 1'b0;
   logic        m_last = 1'b0;
   logic [3:0]  m_keep = '0;
   logic [31:0] m_data = '0;
   logic        m_ready;
   logic [1:0]  ready_mode = 2'd0;
   logic        clear = 1'b0;
   logic [3:0]  rd_addr = '0;
   logic [7:0]  rd_data;
   logic [4:0]  wr_count;
   logic [31:0] pkt_count;
   logic        pkt_done;
   logic [4:0]  pkt_len;
   logic        full;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   axis_capture_sink #(
      .WORD_W(8), .BUS_W(32), .DEPTH(DEPTH), .PROB_READY(20), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .m_valid(m_valid), .m_last(m_last), .m_keep(m_keep),
      .m_data(m_data), .m_ready(m_ready), .ready_mode(ready_mode), .clear(clear),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_count(wr_count), .pkt_count(pkt_count),
      .pkt_done(pkt_done), .pkt_len(pkt_len), .full(full)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          e_ready, e_done, e_tog, e_rd_known;
   int          e_wc, e_cur, e_plen;
   logic [31:0] e_pc;
   logic [15:0] e_lfsr;
   logic [7:0]  e_rd;
   logic [7:0]  e_mem [DEPTH];
   bit          e_known [DEPTH];
   bit          gen, acc;

   initial begin
      for (int i = 0; i < DEPTH; i++) e_known[i] = 1'b0;
      e_rd_known = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) begin
         e_ready = 0; e_done = 0; e_tog = 0; e_wc = 0; e_cur = 0; e_plen = 0;
         e_pc = 0; e_lfsr = 16'hACE1; e_rd = 8'h00; e_rd_known = 1;
      end else begin
         case (ready_mode)
            2'd0: gen = 1;
            2'd1: gen = (int'(e_lfsr[7:0]) < THRESH);
            2'd2: gen = 0;
            default: gen = e_tog;
         endcase
         acc = m_valid && e_ready;
         e_rd_known = e_known[rd_addr];
         e_rd = e_mem[rd_addr];
         e_done = 0;
         if (clear) begin
            e_wc = 0; e_cur = 0; e_pc = 0; e_plen = 0;
         end else if (acc) begin
            for (int i = 0; i < WPB; i++) begin
               if (m_keep[i] && e_wc < DEPTH) begin
                  e_mem[e_wc] = m_data[i*8 +: 8];
                  e_known[e_wc] = 1;
                  e_wc++;
                  e_cur++;
               end
            end
            if (m_last) begin
               e_done = 1; e_plen = e_cur; e_pc = e_pc + 1; e_cur = 0;
            end
         end
         e_ready = gen && !clear && (DEPTH - e_wc >= WPB);
         e_lfsr = {e_lfsr[14:0], e_lfsr[15] ^ e_lfsr[13] ^ e_lfsr[12] ^ e_lfsr[10]};
         e_tog = !e_tog;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ready",   32'(m_ready),  32'(e_ready));
         chk("wr_count",  32'(wr_count), 32'(e_wc));
         chk("pkt_count", pkt_count,     e_pc);
         chk("pkt_done",  32'(pkt_done), 32'(e_done));
         chk("pkt_len",   32'(pkt_len),  32'(e_plen));
         chk("full",      32'(full),     32'(DEPTH - e_wc < WPB));
         if (e_rd_known) chk("rd_data", 32'(rd_data), 32'(e_rd));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [3:0] k, input logic [31:0] d, input bit l);
      int n;
      @(negedge clk);
      m_valid = 1; m_keep = k; m_data = d; m_last = l;
      n = 0;
      while (!e_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++; failures++;
         $display("FAIL send_timeout actual=no_ready required=ready within 200 cycles");
      end
      @(negedge clk);
      m_valid = 0; m_keep = '0; m_last = 0;
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1;
      @(negedge clk); clear = 0;
   endtask

   task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input string name);
      @(negedge clk); rd_addr = a;
      @(negedge clk); chk(name, 32'(rd_data), 32'(exp));
   endtask

   int cnt;

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      chk_en = 1;
      chk("rst_m_ready", 32'(m_ready), 0);
      chk("rst_wr_count", 32'(wr_count), 0);
      chk("rst_pkt_count", pkt_count, 0);
      chk("rst_pkt_len", 32'(pkt_len), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      rst = 0;

      // three full beats, bytes 1..12
      for (int b = 0; b < 3; b++)
         send(4'hF, {8'(4*b+4), 8'(4*b+3), 8'(4*b+2), 8'(4*b+1)}, b == 2);
      chk("t1_pkt_done", 32'(pkt_done), 1);
      chk("t1_pkt_len", 32'(pkt_len), 12);
      chk("t1_pkt_count", pkt_count, 1);
      for (int a = 0; a < 12; a++) read_chk(4'(a), 8'(a + 1), "t1_rd");

      // sparse keep compaction
      pulse_clear();
      send(4'b0101, 32'h04030201, 1);
      chk("t2_pkt_len", 32'(pkt_len), 2);
      chk("t2_wr_count", 32'(wr_count), 2);
      read_chk(4'd0, 8'h01, "t2_mem0");
      read_chk(4'd1, 8'h03, "t2_mem1");

      // fill to capacity, stall, then clear
      pulse_clear();
      for (int b = 0; b < 4; b++) send(4'hF, 32'hA0A0A0A0 + 32'(b), 0);
      @(negedge clk); m_valid = 1; m_keep = 4'hF;
      repeat (5) @(negedge clk);
      chk("t3_wr_count", 32'(wr_count), 16);
      chk("t3_full", 32'(full), 1);
      chk("t3_stall", 32'(m_ready), 0);
      clear = 1;
      @(negedge clk); clear = 0;
      chk("t3_clr_wr_count", 32'(wr_count), 0);
      chk("t3_clr_ready0", 32'(m_ready), 0);
      @(negedge clk);
      chk("t3_clr_ready1", 32'(m_ready), 1);
      m_valid = 0; m_keep = '0;

      // reset mid-packet
      send(4'hF, 32'h11111111, 0);
      send(4'hF, 32'h22222222, 0);
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
      chk("t5_ready", 32'(m_ready), 0);
      chk("t5_wr_count", 32'(wr_count), 0);
      chk("t5_pkt_count", pkt_count, 0);
      send(4'hF, 32'hDDCCBBAA, 1);
      chk("t5_pkt_len", 32'(pkt_len), 4);
      chk("t5_pkt_count2", pkt_count, 1);

      // lone keep=0 last beat, then handshake during clear
      send(4'h0, 32'h0, 1);
      chk("t6_pkt_done", 32'(pkt_done), 1);
      chk("t6_pkt_len", 32'(pkt_len), 0);
      chk("t6_pkt_count", pkt_count, 2);
      chk("t6_wr_count", 32'(wr_count), 4);
      @(negedge clk);
      chk("t6_ready_pre", 32'(m_ready), 1);
      m_valid = 1; m_keep = 4'hF; m_data = 32'h55555555; clear = 1;
      @(negedge clk); m_valid = 0; m_keep = '0; clear = 0;
      chk("t6_discard_wc", 32'(wr_count), 0);
      @(negedge clk);
      chk("t6_discard_wc2", 32'(wr_count), 0);

      // random-mode ready duty with no traffic
      ready_mode = 2'd1;
      @(negedge clk);
      cnt = 0;
      repeat (2000) begin
         @(negedge clk);
         cnt += int'(m_ready);
      end
      checks++;
      if (cnt < 300 || cnt > 500) begin
         failures++;
         $display("FAIL duty actual=%0d required=300..500 of 2000", cnt);
      end

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c % 100 == 0) ready_mode = 2'($urandom_range(0, 3));
         m_valid = ($urandom_range(0, 3) != 0);
         m_keep  = 4'($urandom_range(0, 15));
         m_data  = $urandom;
         m_last  = ($urandom_range(0, 3) == 0);
         rd_addr = 4'($urandom_range(0, 15));
         if (e_wc > DEPTH - WPB) clear = ($urandom_range(0, 7) == 0);
         else                    clear = ($urandom_range(0, 63) == 0);
         rst = ($urandom_range(0, 499) == 0);
      end
      @(negedge clk);
      m_valid = 0; clear = 0; rst = 0;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
